// File: rtl/decode_scoreboard.sv
// ID-stage hazard scoreboard: per-register countdown to forwardability, LL/SC link flag, stall counter.
// Zero-latency combinational stall/pending from current state; the stall output is the only backpressure.
module decode_scoreboard #(
    parameter int NREG_W   = 5,
    parameter int CNT_W    = 3,
    parameter int LOAD_LAT = 1,
    parameter int ALU_LAT  = 0,
    parameter int PERF_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic              issue_we,
    input  logic              issue_is_load,
    input  logic [NREG_W-1:0] issue_waddr,
    input  logic [NREG_W-1:0] rs_addr,
    input  logic              rs_used,
    input  logic [NREG_W-1:0] rt_addr,
    input  logic              rt_used,
    input  logic              flush,
    input  logic              is_ll,
    input  logic              is_sc,
    input  logic              clear_link,
    output logic              stall,
    output logic              rs_pending,
    output logic              rt_pending,
    output logic              busy_any,
    output logic              atomic_id,
    output logic              sc_mask,
    output logic [PERF_W-1:0] stall_cycles
);
    localparam int NREG = 2 ** NREG_W;
    localparam logic [CNT_W-1:0]  LOAD_CNT = LOAD_LAT[CNT_W-1:0];
    localparam logic [CNT_W-1:0]  ALU_CNT  = ALU_LAT[CNT_W-1:0];
    localparam logic [CNT_W-1:0]  CNT_ONE  = 1;
    localparam logic [PERF_W-1:0] PERF_ONE = 1;

    generate
        if (LOAD_LAT >= 2 ** CNT_W || ALU_LAT >= 2 ** CNT_W) begin : g_lat_chk
            $error("decode_scoreboard: LOAD_LAT/ALU_LAT do not fit in CNT_W bits");
        end
    endgenerate

    logic [CNT_W-1:0]  cnt_q [NREG];
    logic [CNT_W-1:0]  cnt_d [NREG];
    logic              atomic_q, atomic_d;
    logic [PERF_W-1:0] perf_q, perf_d;
    logic              accept;

    assign rs_pending   = (rs_addr != '0) && (cnt_q[rs_addr] != '0);
    assign rt_pending   = (rt_addr != '0) && (cnt_q[rt_addr] != '0);
    assign stall        = issue_valid && ((rs_used && rs_pending) || (rt_used && rt_pending));
    assign accept       = issue_valid && !stall && !flush;
    assign atomic_id    = atomic_q;
    assign sc_mask      = is_sc && issue_valid && !atomic_q;
    assign stall_cycles = perf_q;

    always_comb begin
        busy_any = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            if (cnt_q[i] != '0) busy_any = 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            cnt_d[i] = (cnt_q[i] != '0) ? cnt_q[i] - CNT_ONE : '0;
        end
        // Newest writer overrides the running countdown outright (WAW: no max with the old value).
        if (accept && issue_we && issue_waddr != '0) begin
            cnt_d[issue_waddr] = issue_is_load ? LOAD_CNT : ALU_CNT;
        end
        cnt_d[0] = '0;

        atomic_d = atomic_q;
        if (clear_link)            atomic_d = 1'b0;
        else if (accept && is_sc)  atomic_d = 1'b0;
        else if (accept && is_ll)  atomic_d = 1'b1;

        perf_d = perf_q;
        if (stall && perf_q != '1) perf_d = perf_q + PERF_ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) cnt_q[i] <= '0;
            atomic_q <= 1'b0;
            perf_q   <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) cnt_q[i] <= cnt_d[i];
            atomic_q <= atomic_d;
            perf_q   <= perf_d;
        end
    end
endmodule

// File: tb/tb_decode_scoreboard.sv
// Bench for decode_scoreboard: one default instance and one with LOAD_LAT=3, ALU_LAT=1, PERF_W=4.
// Vectors are applied at the falling edge; expected records go through a queue and are checked before the rising edge.
module tb_decode_scoreboard;
    logic       clk;
    logic       rst;
    logic       issue_valid, issue_we, issue_is_load;
    logic [4:0] issue_waddr, rs_addr, rt_addr;
    logic       rs_used, rt_used, flush, is_ll, is_sc, clear_link;

    logic        a_stall, a_rsp, a_rtp, a_busy, a_atom, a_scm;
    logic [31:0] a_scyc;
    logic        b_stall, b_rsp, b_rtp, b_busy, b_atom, b_scm;
    logic [3:0]  b_scyc;

    decode_scoreboard dut_a (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_we(issue_we),
        .issue_is_load(issue_is_load), .issue_waddr(issue_waddr),
        .rs_addr(rs_addr), .rs_used(rs_used), .rt_addr(rt_addr), .rt_used(rt_used),
        .flush(flush), .is_ll(is_ll), .is_sc(is_sc), .clear_link(clear_link),
        .stall(a_stall), .rs_pending(a_rsp), .rt_pending(a_rtp), .busy_any(a_busy),
        .atomic_id(a_atom), .sc_mask(a_scm), .stall_cycles(a_scyc)
    );

    decode_scoreboard #(.NREG_W(5), .CNT_W(3), .LOAD_LAT(3), .ALU_LAT(1), .PERF_W(4)) dut_b (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_we(issue_we),
        .issue_is_load(issue_is_load), .issue_waddr(issue_waddr),
        .rs_addr(rs_addr), .rs_used(rs_used), .rt_addr(rt_addr), .rt_used(rt_used),
        .flush(flush), .is_ll(is_ll), .is_sc(is_sc), .clear_link(clear_link),
        .stall(b_stall), .rs_pending(b_rsp), .rt_pending(b_rtp), .busy_any(b_busy),
        .atomic_id(b_atom), .sc_mask(b_scm), .stall_cycles(b_scyc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       sel;   // 0: default instance, 1: LOAD_LAT=3 instance
        bit       rst;
        bit [2:0] vwl;   // {issue_valid, issue_we, issue_is_load}
        bit [4:0] wa, rs, rt;
        bit       rsu, rtu;
        bit [3:0] fls;   // {flush, is_ll, is_sc, clear_link}
        bit       chk;
        bit [5:0] ex;    // {stall, rs_pending, rt_pending, busy_any, atomic_id, sc_mask}
        int       scyc;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(bit sel, bit r, bit [2:0] vwl, bit [4:0] wa, bit [4:0] rs, bit rsu,
                                bit [4:0] rt, bit rtu, bit [3:0] fls, bit chk, bit [5:0] ex, int scyc);
        vec_t v;
        v.sel = sel; v.rst = r; v.vwl = vwl; v.wa = wa; v.rs = rs; v.rsu = rsu;
        v.rt = rt; v.rtu = rtu; v.fls = fls; v.chk = chk; v.ex = ex; v.scyc = scyc;
        return v;
    endfunction

    task automatic cmp(input string nm, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s vec %0d actual %0d expected %0d", nm, idx, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        vec_t e;
        bit [5:0] act;
        int sc;
        @(negedge clk);
        rst = v.rst;
        {issue_valid, issue_we, issue_is_load} = v.vwl;
        issue_waddr = v.wa; rs_addr = v.rs; rs_used = v.rsu; rt_addr = v.rt; rt_used = v.rtu;
        {flush, is_ll, is_sc, clear_link} = v.fls;
        if (v.chk) exp_q.push_back(v);
        #2;
        if (v.chk) begin
            e = exp_q.pop_front();
            if (e.sel) begin
                act = {b_stall, b_rsp, b_rtp, b_busy, b_atom, b_scm};
                sc  = int'(b_scyc);
            end else begin
                act = {a_stall, a_rsp, a_rtp, a_busy, a_atom, a_scm};
                sc  = int'(a_scyc);
            end
            cmp("stall",        idx, int'(act[5]), int'(e.ex[5]));
            cmp("rs_pending",   idx, int'(act[4]), int'(e.ex[4]));
            cmp("rt_pending",   idx, int'(act[3]), int'(e.ex[3]));
            cmp("busy_any",     idx, int'(act[2]), int'(e.ex[2]));
            cmp("atomic_id",    idx, int'(act[1]), int'(e.ex[1]));
            cmp("sc_mask",      idx, int'(act[0]), int'(e.ex[0]));
            cmp("stall_cycles", idx, sc, e.scyc);
        end
    endtask

    initial begin
        int exp_sc;
        bit st;
        rst = 1'b1;
        {issue_valid, issue_we, issue_is_load} = 3'b000;
        issue_waddr = '0; rs_addr = '0; rt_addr = '0;
        {rs_used, rt_used, flush, is_ll, is_sc, clear_link} = 6'b0;

        // Default instance: load-use, $0, flush, LL/SC.
        vecs.push_back(mk(0,1,3'b000, 0, 0,0, 0,0,4'b0000,0,6'b000000,0));
        vecs.push_back(mk(0,0,3'b000, 0, 0,0, 0,0,4'b0000,1,6'b000000,0)); // reset state
        vecs.push_back(mk(0,0,3'b111, 2, 0,0, 0,0,4'b0000,1,6'b000000,0)); // LW $2
        vecs.push_back(mk(0,0,3'b110, 3, 2,1, 4,1,4'b0000,1,6'b110100,0)); // ADDU $3,$2,$4 stalls
        vecs.push_back(mk(0,0,3'b110, 3, 2,1, 4,1,4'b0000,1,6'b000000,1)); // accepted
        vecs.push_back(mk(0,0,3'b111, 0, 0,0, 0,0,4'b0000,1,6'b000000,1)); // LW $0
        vecs.push_back(mk(0,0,3'b100, 0, 0,1, 0,1,4'b0000,1,6'b000000,1)); // use $0
        vecs.push_back(mk(0,0,3'b111, 2, 0,0, 0,0,4'b0000,1,6'b000000,1)); // LW $2
        vecs.push_back(mk(0,0,3'b111, 7, 2,1, 0,0,4'b1000,1,6'b110100,1)); // LW $7 stalled+flushed
        vecs.push_back(mk(0,0,3'b000, 0, 7,0, 0,0,4'b0000,1,6'b000000,2)); // cnt[7] untouched
        vecs.push_back(mk(0,0,3'b111, 7, 0,0, 0,0,4'b1000,1,6'b000000,2)); // LW $7 flushed only
        vecs.push_back(mk(0,0,3'b100, 0, 7,1, 0,0,4'b0000,1,6'b000000,2));
        vecs.push_back(mk(0,0,3'b111, 8, 0,0, 0,0,4'b0100,1,6'b000000,2)); // LL
        vecs.push_back(mk(0,0,3'b110, 9, 0,0, 0,0,4'b0010,1,6'b000110,2)); // SC with link
        vecs.push_back(mk(0,0,3'b111,10, 0,0, 0,0,4'b0100,1,6'b000000,2)); // LL
        vecs.push_back(mk(0,0,3'b000, 0, 0,0, 0,0,4'b0001,1,6'b000110,2)); // clear_link
        vecs.push_back(mk(0,0,3'b100, 0, 0,0, 0,0,4'b0010,1,6'b000001,2)); // SC masked
        vecs.push_back(mk(0,0,3'b100, 0, 0,0, 0,0,4'b0101,1,6'b000000,2)); // LL + clear_link
        vecs.push_back(mk(0,0,3'b000, 0, 0,0, 0,0,4'b0000,1,6'b000000,2)); // clear wins
        vecs.push_back(mk(0,0,3'b111,11, 0,0, 0,0,4'b0000,1,6'b000000,2)); // LW $11
        vecs.push_back(mk(0,0,3'b100, 0,11,1, 0,0,4'b0100,1,6'b110100,2)); // stalled LL
        vecs.push_back(mk(0,0,3'b000, 0, 0,0, 0,0,4'b0000,1,6'b000000,3)); // link not set
        vecs.push_back(mk(0,0,3'b000, 0, 0,0, 0,0,4'b0010,1,6'b000000,3)); // SC without valid

        // LOAD_LAT=3 / ALU_LAT=1 instance: long stall, ALU latency, WAW, reset.
        vecs.push_back(mk(1,1,3'b000, 0, 0,0, 0,0,4'b0000,0,6'b000000,0));
        vecs.push_back(mk(1,0,3'b000, 0, 0,0, 0,0,4'b0000,1,6'b000000,0));
        vecs.push_back(mk(1,0,3'b111, 5, 0,0, 0,0,4'b0000,1,6'b000000,0)); // LW $5
        vecs.push_back(mk(1,0,3'b110, 6, 0,0, 5,1,4'b0000,1,6'b101100,0));
        vecs.push_back(mk(1,0,3'b110, 6, 0,0, 5,1,4'b0000,1,6'b101100,1));
        vecs.push_back(mk(1,0,3'b110, 6, 0,0, 5,1,4'b0000,1,6'b101100,2));
        vecs.push_back(mk(1,0,3'b110, 6, 0,0, 5,1,4'b0000,1,6'b000000,3)); // accepted, cnt[6]=1
        vecs.push_back(mk(1,0,3'b100, 0, 1,1, 2,1,4'b0000,1,6'b000100,3)); // independent
        vecs.push_back(mk(1,0,3'b110, 7, 0,0, 0,0,4'b0000,1,6'b000000,3)); // ALU write $7
        vecs.push_back(mk(1,0,3'b100, 0, 7,1, 0,0,4'b0000,1,6'b110100,3));
        vecs.push_back(mk(1,0,3'b100, 0, 7,1, 0,0,4'b0000,1,6'b000000,4));
        vecs.push_back(mk(1,0,3'b111,12, 0,0, 0,0,4'b0000,1,6'b000000,4)); // LW $12 -> 3
        vecs.push_back(mk(1,0,3'b110,12, 0,0, 0,0,4'b0000,1,6'b000100,4)); // ALU $12 -> 1
        vecs.push_back(mk(1,0,3'b100, 0, 0,0,12,1,4'b0000,1,6'b101100,4));
        vecs.push_back(mk(1,0,3'b100, 0, 0,0,12,1,4'b0000,1,6'b000000,5)); // newest won
        vecs.push_back(mk(1,0,3'b111, 9, 0,0, 0,0,4'b0100,1,6'b000000,5)); // LL $9
        vecs.push_back(mk(1,0,3'b000, 0, 0,0, 0,0,4'b0000,1,6'b000110,5)); // cnt[9]=2 after this
        vecs.push_back(mk(1,1,3'b100, 0, 9,1, 0,0,4'b0100,0,6'b000000,0)); // rst mid-run
        vecs.push_back(mk(1,0,3'b000, 0, 9,0, 0,0,4'b0000,1,6'b000000,0));

        // Saturation of the 4-bit stall counter: six rounds of three stalls.
        exp_sc = 0;
        for (int k = 0; k < 6; k++) begin
            vecs.push_back(mk(1,0,3'b111,13, 0,0, 0,0,4'b0000,1,6'b000000,exp_sc));
            for (int j = 1; j <= 4; j++) begin
                st = (j < 4);
                vecs.push_back(mk(1,0,3'b100, 0,13,1, 0,0,4'b0000,1,
                                  st ? 6'b110100 : 6'b000000, exp_sc));
                if (st && exp_sc < 15) exp_sc++;
            end
        end
        vecs.push_back(mk(1,0,3'b000, 0, 0,0, 0,0,4'b0000,1,6'b000000,15));

        foreach (vecs[i]) run_vec(vecs[i], i);

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain leftover %0d required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
